// File: rtl/result_display_ctrl_if.sv
// Task-result bus between the Lab 4 engines and the display controller.
//   sel/start       : source select and run-start level
//   done1/result    : task1 done level and bit count
//   done2/found/loc : task2 done level, hit flag and location
//   digit1/digit0   : BCD tens/units digits
//   blank1/blank0   : HEX1/HEX0 blanking
//   valid/nf        : digits hold a result / task2 finished without a hit
// The slave modport is the display controller; the master modport drives it.
interface result_display_ctrl_if #(
  parameter int W = 5
);
  logic         sel;
  logic         start;
  logic         done1;
  logic [3:0]   result;
  logic         done2;
  logic         found;
  logic [W-1:0] loc;
  logic [3:0]   digit1;
  logic [3:0]   digit0;
  logic         blank1;
  logic         blank0;
  logic         valid;
  logic         nf;

  modport slave (
    input  sel, start, done1, result, done2, found, loc,
    output digit1, digit0, blank1, blank0, valid, nf
  );

  modport master (
    output sel, start, done1, result, done2, found, loc,
    input  digit1, digit0, blank1, blank0, valid, nf
  );
endinterface

// File: rtl/result_display_ctrl.sv
// Display controller for the Lab 4 task1/task2 engines.
// Captures the selected task's result on the rising edge of its done level,
// converts it to two BCD digits with a sequential double-dabble (one step per
// cycle), and holds the digits with blanking and not-found flags.
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : result_display_ctrl_if.slave (task inputs, display outputs)
// All outputs are registered.
module result_display_ctrl #(
  parameter int W = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  result_display_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

  state_t       state;
  logic         sel_q, start_q, dsel_q;
  logic [W-1:0] shreg;
  logic [7:0]   acc;
  logic [2:0]   cnt;

  logic         dsel;
  logic         sel_chg, start_rise, done_rise;
  logic [7:0]   acc_adj;

  assign dsel       = bus.sel ? bus.done2 : bus.done1;
  assign sel_chg    = bus.sel != sel_q;
  assign start_rise = bus.start & ~start_q;
  assign done_rise  = dsel & ~dsel_q;

  // add-3 correction applied to each BCD nibble before the shift
  always_comb begin
    acc_adj = acc;
    if (acc[3:0] >= 4'd5) acc_adj[3:0] = acc[3:0] + 4'd3;
    if (acc[7:4] >= 4'd5) acc_adj[7:4] = acc[7:4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel_q      <= 1'b0;
      start_q    <= 1'b0;
      dsel_q     <= 1'b0;
      shreg      <= '0;
      acc        <= '0;
      cnt        <= '0;
      bus.digit1 <= 4'd0;
      bus.digit0 <= 4'd0;
      bus.blank1 <= 1'b1;
      bus.blank0 <= 1'b1;
      bus.valid  <= 1'b0;
      bus.nf     <= 1'b0;
    end else begin
      sel_q   <= bus.sel;
      start_q <= bus.start;
      dsel_q  <= dsel;

      if (sel_chg) begin
        // forcing dsel_q low lets an already-high done on the new source
        // be captured on the next edge
        dsel_q     <= 1'b0;
        state      <= IDLE;
        bus.digit1 <= 4'd0;
        bus.digit0 <= 4'd0;
        bus.blank1 <= 1'b1;
        bus.blank0 <= 1'b1;
        bus.valid  <= 1'b0;
        bus.nf     <= 1'b0;
      end else if (start_rise && state != IDLE) begin
        state      <= IDLE;
        bus.digit1 <= 4'd0;
        bus.digit0 <= 4'd0;
        bus.blank1 <= 1'b1;
        bus.blank0 <= 1'b1;
        bus.valid  <= 1'b0;
        bus.nf     <= 1'b0;
      end else if (done_rise && state != CONVERT) begin
        bus.digit1 <= 4'd0;
        bus.digit0 <= 4'd0;
        bus.blank1 <= 1'b1;
        bus.blank0 <= 1'b1;
        if (bus.sel && !bus.found) begin
          state     <= SHOW;
          bus.valid <= 1'b1;
          bus.nf    <= 1'b1;
        end else begin
          state     <= CONVERT;
          shreg     <= bus.sel ? bus.loc : W'(bus.result);
          acc       <= '0;
          cnt       <= '0;
          bus.valid <= 1'b0;
          bus.nf    <= 1'b0;
        end
      end else if (state == CONVERT) begin
        // W shift steps, then one more edge to publish the digits
        if (cnt == 3'(W)) begin
          state      <= SHOW;
          bus.digit1 <= acc[7:4];
          bus.digit0 <= acc[3:0];
          bus.blank1 <= acc[7:4] == 4'd0;
          bus.blank0 <= 1'b0;
          bus.valid  <= 1'b1;
          bus.nf     <= 1'b0;
        end else begin
          {acc, shreg} <= {acc_adj[6:0], shreg, 1'b0};
          cnt          <= cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_display_ctrl.sv
module tb_result_display_ctrl;
  localparam int W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  result_display_ctrl_if #(.W(W)) bus ();

  result_display_ctrl #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input int d1, input int d0,
                         input int b1, input int b0, input int v, input int n);
    chk({name, ".digit1"}, int'(bus.digit1), d1);
    chk({name, ".digit0"}, int'(bus.digit0), d0);
    chk({name, ".blank1"}, int'(bus.blank1), b1);
    chk({name, ".blank0"}, int'(bus.blank0), b0);
    chk({name, ".valid"},  int'(bus.valid),  v);
    chk({name, ".nf"},     int'(bus.nf),     n);
  endtask

  typedef struct {
    logic       sel;
    logic       found;
    logic [4:0] val;
    int         d1, d0, b1, b0, nf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 5'd9,  0, 9, 1, 0, 0};
    vecs[1] = '{1'b0, 1'b0, 5'd0,  0, 0, 1, 0, 0};
    vecs[2] = '{1'b0, 1'b0, 5'd15, 1, 5, 0, 0, 0};
    vecs[3] = '{1'b1, 1'b1, 5'd27, 2, 7, 0, 0, 0};
    vecs[4] = '{1'b1, 1'b1, 5'd0,  0, 0, 1, 0, 0};
    vecs[5] = '{1'b1, 1'b1, 5'd31, 3, 1, 0, 0, 0};
    vecs[6] = '{1'b1, 1'b1, 5'd10, 1, 0, 0, 0, 0};
    vecs[7] = '{1'b1, 1'b0, 5'd5,  0, 0, 1, 1, 1};

    reset = 1'b1;
    bus.sel = 1'b0; bus.start = 1'b0;
    bus.done1 = 1'b0; bus.result = 4'd0;
    bus.done2 = 1'b0; bus.found = 1'b0; bus.loc = '0;
    tick(); tick();
    chk_all("reset", 0, 0, 1, 1, 0, 0);
    reset = 1'b0;
    tick();

    // table-driven captures
    foreach (vecs[i]) begin
      bus.done1 = 1'b0; bus.done2 = 1'b0; bus.sel = vecs[i].sel;
      tick(); tick();
      bus.found  = vecs[i].found;
      bus.result = vecs[i].val[3:0];
      bus.loc    = vecs[i].val;
      if (vecs[i].sel) bus.done2 = 1'b1; else bus.done1 = 1'b1;
      tick();                                   // capture edge
      if (vecs[i].nf != 0) begin
        chk_all($sformatf("vec%0d", i), vecs[i].d1, vecs[i].d0,
                vecs[i].b1, vecs[i].b0, 1, 1);
      end else begin
        repeat (W) tick();
        chk($sformatf("vec%0d.early_valid", i), int'(bus.valid), 0);
        tick();
        chk_all($sformatf("vec%0d", i), vecs[i].d1, vecs[i].d0,
                vecs[i].b1, vecs[i].b0, 1, 0);
      end
    end

    // done held high: no re-conversion, later input changes ignored
    bus.done1 = 1'b0; bus.done2 = 1'b0; bus.sel = 1'b0;
    tick(); tick();
    bus.result = 4'd9; bus.done1 = 1'b1;
    tick();
    repeat (W + 1) tick();
    bus.result = 4'd3;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("hold%0d.valid", k), int'(bus.valid), 1);
      chk($sformatf("hold%0d.digit0", k), int'(bus.digit0), 9);
    end

    // sel change mid-conversion with task1 done already high
    bus.sel = 1'b1; bus.done1 = 1'b1; bus.result = 4'd4; bus.done2 = 1'b0;
    tick(); tick();
    bus.loc = 5'd20; bus.found = 1'b1; bus.done2 = 1'b1;
    tick();                                     // capture task2
    repeat (3) tick();
    bus.sel = 1'b0;
    tick();
    chk_all("selchg.clear", 0, 0, 1, 1, 0, 0);
    tick();                                     // capture task1
    repeat (W) tick();
    chk("selchg.early_valid", int'(bus.valid), 0);
    tick();
    chk_all("selchg.result", 0, 4, 1, 0, 1, 0);

    // start rise while showing clears outputs
    bus.start = 1'b1;
    tick();
    chk_all("start.clear", 0, 0, 1, 1, 0, 0);
    bus.start = 1'b0;

    // reset mid-conversion: partial result never presented
    bus.done1 = 1'b0;
    tick(); tick();
    bus.result = 4'd7; bus.done1 = 1'b1;
    tick();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    chk_all("rstmid", 0, 0, 1, 1, 0, 0);
    reset = 1'b0;
    // done1 still high and dsel_q cleared, so a full fresh capture follows
    for (int k = 0; k < W + 1; k++) begin
      tick();
      chk($sformatf("rstmid%0d.valid", k), int'(bus.valid), 0);
    end
    tick();
    chk_all("rstmid.result", 0, 7, 1, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
